// File: rtl/sum_activity_monitor.sv
// sum_activity_monitor: per-window toggle, sum and peak-toggle activity monitor.
// Peak tracking is built only when SUM_ACTIVITY_PEAK_EN is defined.
module sum_activity_monitor #(
  parameter int DATA_W  = 5,
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 16,
  localparam int PEAK_W = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_toggles,
  output logic [CNT_W-1:0]  out_total,
  output logic [PEAK_W-1:0] out_peak
);

  localparam int WC_W = $clog2(WIN_LEN);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t state;

  logic [DATA_W-1:0] prev;
  logic [WC_W-1:0]   cnt;
  logic [CNT_W-1:0]  tog_acc;
  logic [CNT_W-1:0]  sum_acc;
  logic [CNT_W-1:0]  tog_q;
  logic [CNT_W-1:0]  sum_q;

  logic [PEAK_W-1:0] d;
  logic [CNT_W:0]    tog_wide;
  logic [CNT_W-1:0]  tog_nxt;
  logic [CNT_W-1:0]  sum_nxt;
  logic              accept;
  logic              last;

  function automatic logic [PEAK_W-1:0] popcnt(
    input logic [DATA_W-1:0] v
  );
    logic [PEAK_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + PEAK_W'(v[i]);
    end
    return n;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == WC_W'(WIN_LEN - 1));

  // One extra carry bit detects toggle overflow for saturation.
  always_comb begin
    d        = popcnt(in_data ^ prev);
    tog_wide = {1'b0, tog_acc} + (CNT_W + 1)'(d);
    tog_nxt  = tog_wide[CNT_W] ? '1 : tog_wide[CNT_W-1:0];
    sum_nxt  = sum_acc + CNT_W'(in_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      prev    <= '0;
      cnt     <= '0;
      tog_acc <= '0;
      sum_acc <= '0;
      tog_q   <= '0;
      sum_q   <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            prev <= in_data;
            if (last) begin
              tog_q   <= tog_nxt;
              sum_q   <= sum_nxt;
              tog_acc <= '0;
              sum_acc <= '0;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              tog_acc <= tog_nxt;
              sum_acc <= sum_nxt;
              cnt     <= cnt + WC_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign out_toggles = tog_q;
  assign out_total   = sum_q;

`ifdef SUM_ACTIVITY_PEAK_EN
  logic [PEAK_W-1:0] peak_acc;
  logic [PEAK_W-1:0] peak_q;
  logic [PEAK_W-1:0] peak_nxt;

  assign peak_nxt = (d > peak_acc) ? d : peak_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_acc <= '0;
      peak_q   <= '0;
    end else if (accept) begin
      if (last) begin
        peak_q   <= peak_nxt;
        peak_acc <= '0;
      end else begin
        peak_acc <= peak_nxt;
      end
    end
  end

  assign out_peak = peak_q;
`else
  assign out_peak = '0;
`endif

endmodule

// File: tb/tb_sum_activity_monitor.sv
// Bench for sum_activity_monitor: table windows, scoreboard,
// saturation, backpressure and asynchronous reset sequences.
module tb_sum_activity_monitor;

  localparam int DW = 5;
  localparam int WL = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_in_valid;
  logic [DW-1:0] a_in_data;
  logic          a_in_ready;
  logic          a_out_valid;
  logic          a_out_ready;
  logic [15:0]   a_tog;
  logic [15:0]   a_tot;
  logic [PW-1:0] a_pk;

  logic          b_in_valid;
  logic [DW-1:0] b_in_data;
  logic          b_in_ready;
  logic          b_out_valid;
  logic          b_out_ready;
  logic [3:0]    b_tog;
  logic [3:0]    b_tot;
  logic [PW-1:0] b_pk;

  sum_activity_monitor #(
    .DATA_W(DW), .WIN_LEN(WL), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_toggles(a_tog),
    .out_total(a_tot), .out_peak(a_pk)
  );

  sum_activity_monitor #(
    .DATA_W(DW), .WIN_LEN(WL), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_toggles(b_tog),
    .out_total(b_tot), .out_peak(b_pk)
  );

  typedef struct {
    logic [15:0]   tog;
    logic [15:0]   tot;
    logic [PW-1:0] pk;
  } res_t;

  typedef struct {
    logic [WL-1:0][DW-1:0] s;
    res_t                  r;
  } vec_t;

  int checks = 0;
  int errors = 0;
  res_t q[$];
  res_t nil = '{tog: '0, tot: '0, pk: '0};

  logic [DW-1:0] m_prev;
  int m_tog, m_tot, m_pk, m_cnt;
  bit prev_xfer;

  function automatic int pc(input logic [DW-1:0] v);
    int n = 0;
    for (int i = 0; i < DW; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [PW-1:0] pk_exp(input int p);
`ifdef SUM_ACTIVITY_PEAK_EN
    return PW'(p);
`else
    return (p < 0) ? PW'(1) : '0;
`endif
  endfunction

  function automatic vec_t mk(input int s0, s1, s2, s3,
                              input int t, s, p);
    vec_t v;
    v.s[0]  = DW'(s0);
    v.s[1]  = DW'(s1);
    v.s[2]  = DW'(s2);
    v.s[3]  = DW'(s3);
    v.r.tog = 16'(t);
    v.r.tot = 16'(s);
    v.r.pk  = pk_exp(p);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_prev    = '0;
    m_tog     = 0;
    m_tot     = 0;
    m_pk      = 0;
    m_cnt     = 0;
    prev_xfer = 1'b0;
  endtask

  task automatic mon();
    res_t r;
    if (prev_xfer) chk("valid_one_cycle", 32'(a_out_valid), 0);
    if (a_out_valid && a_out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: got toggles %0d, expected none",
                 a_tog);
      end else begin
        checks--;
        r = q.pop_front();
        chk("win_toggles", 32'(a_tog), 32'(r.tog));
        chk("win_total", 32'(a_tot), 32'(r.tot));
        chk("win_peak", 32'(a_pk), 32'(r.pk));
      end
    end
    prev_xfer = a_out_valid && a_out_ready;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic send(input logic [DW-1:0] s, input bit use_tbl,
                      input res_t texp, output int waits,
                      output res_t got);
    int d;
    waits = 0;
    got = nil;
    a_in_valid = 1'b1;
    a_in_data = s;
    while (!a_in_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (!a_in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1");
    end else begin
      d = pc(s ^ m_prev);
      m_tog += d;
      m_tot += int'(s);
      if (d > m_pk) m_pk = d;
      m_prev = s;
      m_cnt++;
      if (m_cnt == WL) begin
        got.tog = (m_tog > 65535) ? 16'hffff : 16'(m_tog);
        got.tot = 16'(m_tot);
        got.pk  = pk_exp(m_pk);
        q.push_back(use_tbl ? texp : got);
        m_tog = 0;
        m_tot = 0;
        m_pk  = 0;
        m_cnt = 0;
      end
      tick();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, 32'(a_in_ready), 1);
    chk({nm, "_out_valid"}, 32'(a_out_valid), 0);
    chk({nm, "_toggles"}, 32'(a_tog), 0);
    chk({nm, "_total"}, 32'(a_tot), 0);
    chk({nm, "_peak"}, 32'(a_pk), 0);
  endtask

  vec_t tv[4];
  logic [DW-1:0] bs[8];
  int w;
  res_t got;
  res_t hold_r;

  initial begin
    tv[0] = mk(0, 5, 9, 14, 7, 28, 3);
    tv[1] = mk(14, 14, 14, 1, 4, 43, 4);
    tv[2] = mk(31, 0, 31, 0, 19, 62, 5);
    tv[3] = mk(3, 3, 3, 3, 2, 12, 2);
    bs = '{31, 0, 31, 0, 1, 2, 3, 4};

    rst_n = 1'b0;
    a_in_valid = 1'b0;
    a_in_data = '0;
    a_out_ready = 1'b1;
    b_in_valid = 1'b0;
    b_in_data = '0;
    b_out_ready = 1'b1;
    mdl_reset();
    #1;
    chk_reset("por");
    chk("por_b_in_ready", 32'(b_in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation and wrap on the narrow-counter instance.
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_data = bs[i];
      w = 0;
      while (!b_in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!b_in_ready) begin
        checks++;
        errors++;
        $display("FAIL b_accept_timeout: got in_ready 0, expected 1");
      end
      @(negedge clk);
      if (i == 3) begin
        chk("sat_valid", 32'(b_out_valid), 1);
        chk("sat_toggles", 32'(b_tog), 15);
        chk("sat_total", 32'(b_tot), 14);
        chk("sat_peak", 32'(b_pk), 32'(pk_exp(5)));
      end
      if (i == 7) begin
        chk("nosat_toggles", 32'(b_tog), 7);
        chk("nosat_total", 32'(b_tot), 10);
        chk("nosat_peak", 32'(b_pk), 32'(pk_exp(3)));
      end
    end
    b_in_valid = 1'b0;

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < WL; i++) begin
        send(tv[k].s[i], 1'b1, tv[k].r, w, got);
        chk("bubble", 32'(w), (i == 0 && k > 0) ? 1 : 0);
      end
    end

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < WL; i++) begin
        send(DW'($urandom_range(0, 31)), 1'b0, nil, w, got);
      end
    end
    tick();

    // Backpressure with sample 7 waiting at the input.
    a_out_ready = 1'b0;
    for (int i = 0; i < WL; i++) begin
      send(DW'(i + 1), 1'b0, nil, w, got);
    end
    hold_r = got;
    a_in_valid = 1'b1;
    a_in_data = 5'd7;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(a_in_ready), 0);
      chk("bp_out_valid", 32'(a_out_valid), 1);
      chk("bp_toggles", 32'(a_tog), 32'(hold_r.tog));
      chk("bp_total", 32'(a_tot), 32'(hold_r.tot));
      if (i < 2) tick();
    end
    a_out_ready = 1'b1;
    mon();
    send(5'd7, 1'b0, nil, w, got);
    chk("bp_accept_delay", 32'(w), 1);
    send(5'd5, 1'b0, nil, w, got);
    send(5'd6, 1'b0, nil, w, got);
    send(5'd9, 1'b0, nil, w, got);
    tick();

    // Asynchronous reset mid-window.
    send(5'd10, 1'b0, nil, w, got);
    send(5'd20, 1'b0, nil, w, got);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    chk("rst_mid_queue", 32'(q.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    for (int i = 0; i < WL; i++) begin
      send(tv[0].s[i], 1'b1, tv[0].r, w, got);
    end
    tick();

    // Asynchronous reset while holding a result.
    a_out_ready = 1'b0;
    for (int i = 0; i < WL; i++) begin
      send(tv[1].s[i], 1'b1, tv[1].r, w, got);
    end
    chk("hold_valid", 32'(a_out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_hold");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    a_out_ready = 1'b1;
    for (int i = 0; i < WL; i++) begin
      send(tv[0].s[i], 1'b1, tv[0].r, w, got);
    end
    tick();
    tick();
    chk("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
